// File: rtl/ro_sample_ctrl.sv
// Sequencer between the RO counter bank / adder tree and the absorption FIFO:
// clears counters, runs back-to-back windows, snaps, and writes delayed tree sums.
module ro_sample_ctrl #(
  parameter int ADD_WIDTH        = 19,
  parameter int FIFO_WIDTH       = 20,
  parameter int NUM_SAMPLE_WIDTH = 64,
  parameter int PIPELINE_LATENCY = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        go,
  input  logic                        stop,
  input  logic [NUM_SAMPLE_WIDTH:0]   num_samples,
  input  logic [NUM_SAMPLE_WIDTH:0]   collect_cycles,
  input  logic [ADD_WIDTH-1:0]        ro_sum,
  input  logic                        fifo_full,
  output logic                        ro_clr,
  output logic                        ro_en,
  output logic                        ro_snap,
  output logic                        fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]       fifo_wr_data,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output logic [NUM_SAMPLE_WIDTH:0]   samples_written
);

  localparam int CW = NUM_SAMPLE_WIDTH + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_COLLECT = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           num_q, num_d;
  logic [CW-1:0]           win_last_q, win_last_d;
  logic [CW-1:0]           win_q, win_d;
  logic [CW-1:0]           issued_q, issued_d;
  logic [CW-1:0]           issued_inc;
  logic [CW-1:0]           sw_q, sw_d;
  logic                    ovf_q, ovf_d;
  logic [PIPELINE_LATENCY-1:0] dl_q;
  logic                    sum_vld;
  logic                    pend_q;
  logic [FIFO_WIDTH-1:0]   sum_fit;
  logic [FIFO_WIDTH-1:0]   sum_q;
  logic [FIFO_WIDTH-1:0]   last_q;
  logic                    start;

  assign issued_inc = issued_q + ONE;
  assign sum_vld    = dl_q[PIPELINE_LATENCY-1];
  assign start      = go && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Narrow FIFOs saturate rather than wrap so an oversized sum reads as "max".
  generate
    if (FIFO_WIDTH > ADD_WIDTH) begin : g_zext
      assign sum_fit = {{(FIFO_WIDTH-ADD_WIDTH){1'b0}}, ro_sum};
    end else if (FIFO_WIDTH == ADD_WIDTH) begin : g_same
      assign sum_fit = ro_sum;
    end else begin : g_sat
      assign sum_fit = (|ro_sum[ADD_WIDTH-1:FIFO_WIDTH]) ? {FIFO_WIDTH{1'b1}}
                                                        : ro_sum[FIFO_WIDTH-1:0];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    win_last_d = win_last_q;
    win_d      = win_q;
    issued_d   = issued_q;
    ro_clr     = 1'b0;
    ro_en      = 1'b0;
    ro_snap    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          num_d      = num_samples;
          win_last_d = (collect_cycles == '0) ? '0 : (collect_cycles - ONE);
          win_d      = '0;
          issued_d   = '0;
          state_d    = (num_samples == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        ro_clr  = 1'b1;
        state_d = stop ? S_DRAIN : S_COLLECT;
      end
      S_COLLECT: begin
        ro_en = 1'b1;
        // A stop on what would be the last window cycle also suppresses that snap.
        if (stop) begin
          state_d = S_DRAIN;
        end else if (win_q == win_last_q) begin
          ro_snap  = 1'b1;
          win_d    = '0;
          issued_d = issued_inc;
          if (issued_inc == num_q) state_d = S_DRAIN;
        end else begin
          win_d = win_q + ONE;
        end
      end
      S_DRAIN: begin
        // The sample leaving the delay line this cycle is written next cycle,
        // so an empty line here means the last write is in progress now.
        if (dl_q == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fifo_wr_en      = pend_q && !fifo_full;
  assign fifo_wr_data    = fifo_wr_en ? sum_q : last_q;
  assign busy            = (state_q == S_CLEAR) || (state_q == S_COLLECT) || (state_q == S_DRAIN);
  assign done            = (state_q == S_DONE);
  assign overflow        = ovf_q;
  assign samples_written = sw_q;

  always_comb begin
    sw_d  = sw_q;
    ovf_d = ovf_q;
    if (start) begin
      sw_d  = '0;
      ovf_d = 1'b0;
    end else if (pend_q) begin
      if (fifo_full) ovf_d = 1'b1;
      else           sw_d  = sw_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      num_q      <= '0;
      win_last_q <= '0;
      win_q      <= '0;
      issued_q   <= '0;
      sw_q       <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      win_last_q <= win_last_d;
      win_q      <= win_d;
      issued_q   <= issued_d;
      sw_q       <= sw_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_q   <= '0;
      pend_q <= 1'b0;
      sum_q  <= '0;
      last_q <= '0;
    end else begin
      dl_q[0] <= ro_snap;
      for (int i = 1; i < PIPELINE_LATENCY; i++) begin
        dl_q[i] <= dl_q[i-1];
      end
      pend_q <= sum_vld;
      if (sum_vld)    sum_q  <= sum_fit;
      if (fifo_wr_en) last_q <= sum_q;
    end
  end

endmodule

// File: tb/tb_ro_sample_ctrl.sv
// Directed bench for ro_sample_ctrl: per-cycle output masks compared to
// hand-derived cycle numbers, plus a saturating narrow-FIFO instance.
module tb_ro_sample_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        go, stop, fifo_full;
  logic [64:0] num_samples, collect_cycles;
  logic [18:0] ro_sum;
  logic [21:0] ro_sum_w;

  logic        ro_clr, ro_en, ro_snap, fifo_wr_en, busy, done, overflow;
  logic [19:0] fifo_wr_data;
  logic [64:0] samples_written;

  logic        w_clr, w_en, w_snap, w_wr_en, w_busy, w_done, w_ovf;
  logic [19:0] w_data;
  logic [64:0] w_sw;

  always #5 clk = ~clk;

  ro_sample_ctrl u_dut (
    .clk(clk), .rst(rst), .go(go), .stop(stop),
    .num_samples(num_samples), .collect_cycles(collect_cycles),
    .ro_sum(ro_sum), .fifo_full(fifo_full),
    .ro_clr(ro_clr), .ro_en(ro_en), .ro_snap(ro_snap),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .busy(busy), .done(done), .overflow(overflow),
    .samples_written(samples_written)
  );

  ro_sample_ctrl #(.ADD_WIDTH(22), .FIFO_WIDTH(20)) u_sat (
    .clk(clk), .rst(rst), .go(go), .stop(stop),
    .num_samples(num_samples), .collect_cycles(collect_cycles),
    .ro_sum(ro_sum_w), .fifo_full(fifo_full),
    .ro_clr(w_clr), .ro_en(w_en), .ro_snap(w_snap),
    .fifo_wr_en(w_wr_en), .fifo_wr_data(w_data),
    .busy(w_busy), .done(w_done), .overflow(w_ovf),
    .samples_written(w_sw)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] clr_m, snap_m, wr_m, done_m, rst_outs;
  logic        both_hi, ov0;
  logic [19:0] wq[$];
  logic [19:0] wq_w[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One run: go at cycle 0, optional one-cycle stop / fifo_full / reset at given cycles.
  task automatic run(input int n, input int c, input int len,
                     input int stop_at, input int full_at, input int rst_at);
    clr_m = '0; snap_m = '0; wr_m = '0; done_m = '0; rst_outs = '0;
    both_hi = 1'b0; ov0 = 1'b0;
    wq.delete(); wq_w.delete();
    num_samples    = 65'(n);
    collect_cycles = 65'(c);
    for (int t = 0; t < len; t++) begin
      @(posedge clk); #1;
      if (t == rst_at + 1) rst = 1'b0;
      go        = (t == 0);
      stop      = (t == stop_at);
      fifo_full = (t == full_at);
      ro_sum    = 19'(t);
      if (t == rst_at) begin
        #2 rst = 1'b1;
      end
      @(negedge clk);
      if (ro_clr)          clr_m[t]  = 1'b1;
      if (ro_snap)         snap_m[t] = 1'b1;
      if (fifo_wr_en)      wr_m[t]   = 1'b1;
      if (done && t > 0)   done_m[t] = 1'b1;
      if (busy && done)    both_hi   = 1'b1;
      if (fifo_wr_en)      wq.push_back(fifo_wr_data);
      if (w_wr_en)         wq_w.push_back(w_data);
      if (t == 0)          ov0 = overflow;
      if (t == rst_at)
        rst_outs = 64'({ro_clr, ro_en, ro_snap, fifo_wr_en, busy, done, overflow,
                        |samples_written, |fifo_wr_data,
                        w_clr, w_en, w_snap, w_wr_en, w_busy, w_done, w_ovf,
                        |w_sw, |w_data});
    end
    go = 1'b0; stop = 1'b0; fifo_full = 1'b0;
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; stop = 1'b0; fifo_full = 1'b0;
    num_samples = '0; collect_cycles = '0; ro_sum = '0; ro_sum_w = 22'h3FFFFF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 64'({ro_clr, ro_en, ro_snap, fifo_wr_en, busy, done, overflow,
                            |samples_written, |fifo_wr_data}), 64'h0);
    rst = 1'b0;

    // Nominal: C=4 N=3
    run(3, 4, 24, -1, -1, -1);
    check("nom_clr",  clr_m,  64'h2);
    check("nom_snap", snap_m, 64'h2220);
    check("nom_wr",   wr_m,   64'h88800);
    check("nom_done", done_m, 64'hF00000);
    check("nom_bsy_done", 64'(both_hi), 64'h0);
    check("nom_nwr",  64'(wq.size()), 64'd3);
    if (wq.size() == 3) begin
      check("nom_d0", 64'(wq[0]), 64'd10);
      check("nom_d1", 64'(wq[1]), 64'd14);
      check("nom_d2", 64'(wq[2]), 64'd18);
    end
    check("nom_sw",   samples_written[63:0], 64'd3);
    check("nom_ovf",  64'(overflow), 64'h0);
    check("nom_hold", 64'(fifo_wr_data), 64'd18);
    check("sat_nwr",  64'(wq_w.size()), 64'd3);
    for (int i = 0; i < wq_w.size(); i++) check("sat_data", 64'(wq_w[i]), 64'hFFFFF);

    // Zero samples, restarted from DONE
    run(0, 4, 6, -1, -1, -1);
    check("zero_clr",  clr_m,  64'h0);
    check("zero_snap", snap_m, 64'h0);
    check("zero_wr",   wr_m,   64'h0);
    check("zero_done", done_m, 64'h3E);

    // Minimum window: C=0 behaves as 1
    run(4, 0, 16, -1, -1, -1);
    check("min_clr",  clr_m,  64'h2);
    check("min_snap", snap_m, 64'h3C);
    check("min_wr",   wr_m,   64'hF00);
    check("min_done", done_m, 64'hF000);
    check("min_sw",   samples_written[63:0], 64'd4);
    if (wq.size() == 4) begin
      check("min_d0", 64'(wq[0]), 64'd7);
      check("min_d3", 64'(wq[3]), 64'd10);
    end

    // FIFO full during the second write
    run(3, 4, 24, -1, 15, -1);
    check("full_wr",   wr_m,   64'h80800);
    check("full_done", done_m, 64'hF00000);
    check("full_sw",   samples_written[63:0], 64'd2);
    check("full_ovf",  64'(overflow), 64'h1);
    if (wq.size() == 2) check("full_d1", 64'(wq[1]), 64'd18);

    // Stop mid-window; overflow from previous run persists until go is taken
    run(3, 4, 16, 7, -1, -1);
    check("stop_ov0",  64'(ov0), 64'h1);
    check("stop_snap", snap_m, 64'h20);
    check("stop_wr",   wr_m,   64'h800);
    check("stop_done", done_m, 64'hF000);
    check("stop_sw",   samples_written[63:0], 64'd1);
    check("stop_ovf",  64'(overflow), 64'h0);

    // Asynchronous reset during COLLECT
    run(3, 4, 16, -1, -1, 7);
    check("rst_outs", rst_outs, 64'h0);
    check("rst_snap", snap_m,   64'h20);
    check("rst_wr",   wr_m,     64'h0);
    check("rst_done", done_m,   64'h0);

    // Nominal again after reset
    run(3, 4, 24, -1, -1, -1);
    check("re_wr",   wr_m,   64'h88800);
    check("re_done", done_m, 64'hF00000);
    check("re_sw",   samples_written[63:0], 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ro_sample_ctrl.md
# ro_sample_ctrl

Sequencing stage between the ring-oscillator counter bank / adder tree and the absorption FIFO that feeds the cache-line packer. On `go` it clears the RO counters and opens back-to-back collection windows of `collect_cycles` cycles. At the end of each window it snapshots the counters into the adder tree. It writes each tree sum, `PIPELINE_LATENCY` cycles later, into the FIFO until `num_samples` samples have been taken or `stop` aborts the run.

## Interface
- `ADD_WIDTH`, 19, width of the adder-tree sum.
- `FIFO_WIDTH`, 20, width of a FIFO entry; must be ≥ 1.
- `NUM_SAMPLE_WIDTH`, 64, count operands are `NUM_SAMPLE_WIDTH+1` bits.
- `PIPELINE_LATENCY`, 5, cycles from `ro_snap` to a valid `ro_sum`; must be ≥ 1.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `go` in 1: start pulse; ignored unless in IDLE or DONE.
- `stop` in 1: abort request, level-sampled.
- `num_samples` in NUM_SAMPLE_WIDTH+1: samples to take; latched on accepted `go`.
- `collect_cycles` in NUM_SAMPLE_WIDTH+1: window length; latched on `go`; 0 is treated as 1.
- `ro_sum` in ADD_WIDTH: adder-tree output.
- `fifo_full` in 1: absorption FIFO full.
- `ro_clr` out 1: synchronous clear of RO counters.
- `ro_en` out 1: RO counters count while high.
- `ro_snap` out 1: capture-and-clear pulse to the counters; launches the tree.
- `fifo_wr_en` out 1: FIFO write strobe.
- `fifo_wr_data` out FIFO_WIDTH: sample written.
- `busy` out 1: high in CLEAR, COLLECT and DRAIN.
- `done` out 1: high in DONE.
- `overflow` out 1: sticky; a sample was dropped because the FIFO was full.
- `samples_written` out NUM_SAMPLE_WIDTH+1: count of successful FIFO writes this run.

## Operation
**Reset values.** All outputs reset to 0. The FSM resets to IDLE, and the in-flight delay line resets empty.

**FSM states.** IDLE, CLEAR, COLLECT, DRAIN, DONE.
- **IDLE / DONE.** On `go`:
  - latch both counts;
  - clear `overflow`, `samples_written`, the window counter and the issued counter;
  - go to CLEAR, or directly to DONE if `num_samples`==0.
- **CLEAR.** One cycle. `ro_clr`=1, `ro_en`=0. Next state is COLLECT.
- **COLLECT.**
  - `ro_en`=1; the window counter increments every cycle.
  - On the window's last cycle (counter == max(C,1)−1):
    - `ro_snap`=1;
    - the counter returns to 0 with no gap between windows;
    - issued is incremented.
  - When that snap is the N-th one, go to DRAIN.
- **stop in CLEAR/COLLECT.** Go to DRAIN. No further `ro_snap`; a partial window is discarded and snaps already issued complete normally.
- **DRAIN.** `ro_en`=0. When the delay line holds no pending sample and no write is pending, go to DONE.
- **stop elsewhere.** Ignored in IDLE, DRAIN and DONE.

**Delay line.** A `PIPELINE_LATENCY`-deep shift register of snap flags. Its output marks the cycle in which `ro_sum` is valid.

**Write path.**
- In a cycle where `ro_sum` is valid, capture `ro_sum`; the write is issued in the next cycle.
- **Width rule:**
  - if FIFO_WIDTH ≥ ADD_WIDTH, zero-extend;
  - otherwise saturate to all-ones when any bit above FIFO_WIDTH−1 is set.
- If `fifo_full` is low in the write cycle:
  - `fifo_wr_en`=1;
  - `samples_written` increments.
- If `fifo_full` is high in the write cycle:
  - no write; the sample is dropped, not retried;
  - `overflow` is set.
- `fifo_wr_data` holds its last value when `fifo_wr_en`=0.

**Restart.** `go` in DONE restarts the run. `go` while busy has no effect.

**Reset mid-run.** Returns to IDLE immediately. Pending samples are discarded and no write occurs after reset.

## Timing
- Accepted `go` at cycle 0:
  - `ro_clr` in cycle 1;
  - COLLECT from cycle 2;
  - k-th `ro_snap` at cycle 1+k·C.
- A snap at cycle s has `ro_sum` sampled at s+L and `fifo_wr_en` at s+L+1.
- `done` rises the cycle after the last write cycle (DRAIN exit). In other words, `done` rises at cycle 1+N·C+L+2.
- `busy` and `done` are never high together.
- `samples_written` updates in the cycle after the strobe.
- Maximum sample rate is one per C cycles. There are no back-pressure stalls; the FIFO's full condition only drops samples.

## Test plan
- **Nominal run.** C=4, N=3, L=5, `fifo_full`=0, `ro_sum`=cycle index; `go` at 0.
  - `ro_clr`@1; `ro_snap`@5,9,13; `fifo_wr_en`@11,15,19 with data 10,14,18.
  - `done`@20; `samples_written`=3; `overflow`=0.
- **Zero samples.** N=0, `go`: `done` the next cycle; no `ro_clr`, snap or write.
- **Minimum window.** C=0 (treated as 1), N=4: `ro_snap` on 4 consecutive cycles 2–5; 4 consecutive writes at 8–11.
- **FIFO full.** Hold `fifo_full`=1 during the second write of the nominal run: writes @11 and @19 only; `samples_written`=2; `overflow`=1 until the next `go`.
- **Stop mid-window.** Assert `stop` at cycle 7 of the nominal run: snap @5 only; write @11; `done`@12; `samples_written`=1.
- **Saturation and reset.**
  - ADD_WIDTH=22, FIFO_WIDTH=20, `ro_sum`=0x3FFFFF: `fifo_wr_data`=0xFFFFF.
  - Asserting `rst` during COLLECT clears all outputs asynchronously. No `fifo_wr_en` follows, and a later `go` runs nominally.
